// File: rtl/alarm_ctrl_if.sv
// Alarm controller user/counter bus: time source, setpoint load, user strobes, status.
// Latency: n/a (signal bundle only).
// Backpressure: none; every strobe is sampled in the cycle it is asserted.
interface alarm_ctrl_if;
    logic [16:0] counter_state;
    logic        sec_tick;
    logic        set_load;
    logic [16:0] set_value;
    logic        enable;
    logic        snooze;
    logic        dismiss;
    logic        alarm_state;
    logic        armed;
    logic        snoozing;
    logic [16:0] setpoint;
    logic        set_err;

    // Driver side: produces time, loads and user strobes, observes status.
    modport master (
        output counter_state, sec_tick, set_load, set_value, enable, snooze, dismiss,
        input  alarm_state, armed, snoozing, setpoint, set_err
    );

    // Controller side.
    modport slave (
        input  counter_state, sec_tick, set_load, set_value, enable, snooze, dismiss,
        output alarm_state, armed, snoozing, setpoint, set_err
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: setpoint register, match/ring/snooze FSM with ring timeout.
// Latency: one cycle from a matching sec_tick (or user strobe) to the status outputs.
// Backpressure: none; strobes are single-cycle and never stalled, ignored ones are dropped.
module alarm_ctrl #(
    parameter int COUNTER_MAX  = 86399,
    parameter int SNOOZE_SEC   = 540,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    alarm_ctrl_if.slave bus
);
    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int SW = $clog2(MAX_SNOOZE + 1);

    localparam logic [16:0]   CMAX = 17'(COUNTER_MAX);
    localparam logic [17:0]   MOD  = 18'(COUNTER_MAX + 1);
    localparam logic [17:0]   SNZ  = 18'(SNOOZE_SEC);
    localparam logic [RW-1:0] RTO  = RW'(RING_TIMEOUT);
    localparam logic [SW-1:0] SMAX = SW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [16:0]   setpoint_q, setpoint_d;
    logic [16:0]   target_q, target_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          set_err_q, set_err_d;

    logic          load_ok;
    logic          load_bad;
    logic          match;
    logic [17:0]   snz_sum;
    logic [16:0]   snz_tgt;

    // Load qualification, exact-match detect and wrapped snooze target.
    always_comb begin
        load_ok  = bus.set_load && (bus.set_value <= CMAX);
        load_bad = bus.set_load && (bus.set_value > CMAX);
        match    = bus.sec_tick && (bus.counter_state == target_q);
        snz_sum  = {1'b0, bus.counter_state} + SNZ;
        snz_tgt  = 17'((snz_sum > {1'b0, CMAX}) ? (snz_sum - MOD) : snz_sum);
    end

    // Next-state logic: disable beats everything, then loads, then per-state behaviour.
    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        target_d   = target_q;
        ring_d     = ring_q;
        snz_cnt_d  = snz_cnt_q;
        set_err_d  = load_bad;

        if (!bus.enable) begin
            state_d = IDLE;
            if (load_ok) begin
                setpoint_d = bus.set_value;
                target_d   = bus.set_value;
                snz_cnt_d  = '0;
            end
        end else if (load_ok) begin
            setpoint_d = bus.set_value;
            target_d   = bus.set_value;
            snz_cnt_d  = '0;
            state_d    = ARMED;
        end else if (load_bad) begin
            // Rejected load freezes everything for this cycle; only set_err reacts.
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ARMED;
                    target_d = setpoint_q;
                end
                ARMED: begin
                    if (match) begin
                        state_d = RINGING;
                        ring_d  = '0;
                    end
                end
                SNOOZE: begin
                    if (bus.dismiss) begin
                        state_d   = ARMED;
                        target_d  = setpoint_q;
                        snz_cnt_d = '0;
                    end else if (match) begin
                        state_d = RINGING;
                        ring_d  = '0;
                    end
                end
                RINGING: begin
                    if (bus.dismiss) begin
                        state_d   = ARMED;
                        target_d  = setpoint_q;
                        snz_cnt_d = '0;
                    end else if (bus.snooze && (snz_cnt_q < SMAX)) begin
                        state_d   = SNOOZE;
                        target_d  = snz_tgt;
                        snz_cnt_d = snz_cnt_q + SW'(1);
                    end else if (bus.sec_tick) begin
                        ring_d = ring_q + RW'(1);
                        if ((ring_q + RW'(1)) == RTO) begin
                            state_d   = ARMED;
                            target_d  = setpoint_q;
                            snz_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            setpoint_q <= '0;
            target_q   <= '0;
            ring_q     <= '0;
            snz_cnt_q  <= '0;
            set_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            target_q   <= target_d;
            ring_q     <= ring_d;
            snz_cnt_q  <= snz_cnt_d;
            set_err_q  <= set_err_d;
        end
    end

    // Status decoded straight from the state register so reset drops it immediately.
    assign bus.alarm_state = (state_q == RINGING);
    assign bus.armed       = (state_q == ARMED) || (state_q == SNOOZE);
    assign bus.snoozing    = (state_q == SNOOZE);
    assign bus.setpoint    = setpoint_q;
    assign bus.set_err     = set_err_q;
endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter COUNTER_MAX, default 86399: last valid timestamp, where 0 = 12:00:00 AM and 86399 = 11:59:59 PM.
REQ-002 Parameter SNOOZE_SEC, default 540: snooze delay in seconds.
REQ-003 Parameter RING_TIMEOUT, default 60: ring duration in seconds before auto-stop.
REQ-004 Parameter MAX_SNOOZE, default 3: number of snoozes allowed per alarm event.
REQ-005 Port clock  input  1: single clock; all state updates on posedge clock.
REQ-006 Port reset_n  input  1: asynchronous, active-low reset.
REQ-007 Port counter_state  input  17: current timestamp from the seconds counter.
REQ-008 Port sec_tick  input  1: one-cycle strobe; counter_state holds a new value in this cycle.
REQ-009 Port set_load  input  1: one-cycle strobe to load set_value as the alarm setpoint.
REQ-010 Port set_value  input  17: requested setpoint timestamp.
REQ-011 Port enable  input  1: level; 1 = alarm armed, 0 = alarm disabled.
REQ-012 Port snooze  input  1: one-cycle user snooze strobe.
REQ-013 Port dismiss  input  1: one-cycle user dismiss strobe.
REQ-014 Port alarm_state  output  1: registered; 1 while the alarm is ringing.
REQ-015 Port armed  output  1: registered; 1 in ARMED or SNOOZE.
REQ-016 Port snoozing  output  1: registered; 1 in SNOOZE.
REQ-017 Port setpoint  output  17: current stored setpoint.
REQ-018 Port set_err  output  1: one-cycle pulse when a load is rejected.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARMED, RINGING and SNOOZE; an internal 17-bit target register SHALL hold the next match time.
REQ-020 A set_load with set_value <= COUNTER_MAX SHALL update setpoint and target on the next edge, clear the snooze count, and enter ARMED if enable=1, else IDLE.
REQ-021 A set_load with set_value > COUNTER_MAX SHALL leave all state unchanged and pulse set_err for exactly one cycle.
REQ-022 With enable=0, any state SHALL go to IDLE on the next edge; this has priority over all other inputs except reset.
REQ-023 In IDLE with enable=1, the FSM SHALL go to ARMED with target=setpoint on the next edge.
REQ-024 In ARMED or SNOOZE, sec_tick=1 with counter_state==target SHALL enter RINGING, clear the ring counter, and set alarm_state=1 on the same edge, i.e. one cycle after the tick.
REQ-025 Matching SHALL be exact equality sampled only on sec_tick cycles; counter_state changes without sec_tick are ignored.
REQ-026 In RINGING, the ring counter SHALL increment on each sec_tick; when it reaches RING_TIMEOUT, the FSM SHALL go to ARMED with target=setpoint and the snooze count cleared.
REQ-027 In RINGING, dismiss SHALL go to ARMED with target=setpoint and the snooze count cleared.
REQ-028 In RINGING, snooze with snooze count < MAX_SNOOZE SHALL go to SNOOZE, increment the count, and set target=(counter_state+SNOOZE_SEC) mod (COUNTER_MAX+1).
REQ-029 The snooze-target sum SHALL be computed in 18 bits, subtracting COUNTER_MAX+1 when the sum exceeds COUNTER_MAX.
REQ-030 In RINGING, snooze with snooze count == MAX_SNOOZE SHALL be ignored, and ringing continues.
REQ-031 In SNOOZE, dismiss SHALL go to ARMED with target=setpoint and the snooze count cleared.
REQ-032 When dismiss and snooze occur in the same cycle, dismiss SHALL win.
REQ-033 When set_load and dismiss or snooze occur in the same cycle, set_load SHALL win.
REQ-034 When a match tick and a valid set_load coincide, set_load SHALL win and the FSM SHALL NOT ring that tick.
REQ-035 snooze and dismiss SHALL be ignored in IDLE and ARMED.
REQ-036 Outputs SHALL be decoded from the registered state: alarm_state=(RINGING), armed=(ARMED|SNOOZE), snoozing=(SNOOZE).

Reset
REQ-037 On reset_n=0, the block SHALL immediately enter IDLE and clear setpoint, target, the ring counter, the snooze count, alarm_state, armed, snoozing and set_err to 0.
REQ-038 Reset asserted mid-ring SHALL drop alarm_state asynchronously.
REQ-039 After reset release, the first edge SHALL follow the IDLE rules.

Verification
REQ-040 Load 25200 with enable=1, then ticks 25199 and 25200 -> alarm_state=1 exactly one cycle after the 25200 tick.
REQ-041 Ringing at 86000, snooze -> target=140 (wraps past midnight); tick 140 -> ring again; snoozing=1 in between.
REQ-042 Ring 60 ticks with no input -> alarm_state falls after the 60th tick, armed=1, and the next day's match rings again.
REQ-043 Three snoozes, then a fourth snooze while ringing -> ignored, alarm_state stays 1; dismiss -> ARMED with snooze count 0.
REQ-044 set_load=86400 -> one-cycle set_err, setpoint unchanged; set_load together with dismiss, and set_load together with a match tick -> set_load wins and no ring.
REQ-045 reset_n=0 while ringing -> alarm_state=0 without waiting for a clock edge; enable=0 while in SNOOZE -> IDLE on the next edge.
